// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised 2R/1W register file with masked writes, bypass and sequenced clear
// Reads are registered; the clear engine sweeps one entry per cycle while busy is high.
module reg_file_param #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 read_en,
  input  logic                 write_en,
  input  logic [ADDR_W-1:0]    read_addr1,
  input  logic [ADDR_W-1:0]    read_addr2,
  input  logic [ADDR_W-1:0]    write_addr,
  input  logic [DATA_W-1:0]    data,
  input  logic [DATA_W/8-1:0]  wr_mask,
  input  logic                 clear_req,
  output logic [DATA_W-1:0]    read_out1,
  output logic [DATA_W-1:0]    read_out2,
  output logic                 read_valid,
  output logic                 busy
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_A  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d;
  logic                valid_q, valid_d;
  logic                access, wr_ok;
  logic [DATA_W-1:0]   old_w, merged;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_A;
  endfunction

  // Resolves one read port: out-of-range and hardwired r0 read zero, bypass forwards the merged write.
  function automatic logic [DATA_W-1:0] port_val(input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] entry,
                                                 input logic wok,
                                                 input logic [ADDR_W-1:0] wa,
                                                 input logic [DATA_W-1:0] mg);
    if (!in_range(a) || (R0_ZERO != 0 && a == '0)) return '0;
    if (BYPASS != 0 && wok && a == wa) return mg;
    return entry;
  endfunction

  assign access = enable && (state_q == IDLE) && !clear_req;
  assign wr_ok  = access && write_en && in_range(write_addr) &&
                  !(R0_ZERO != 0 && write_addr == '0);
  assign old_w  = in_range(write_addr) ? mem_q[write_addr] : '0;

  always_comb begin
    merged = old_w;
    for (int b = 0; b < NB; b++) begin
      if (wr_mask[b]) merged[8*b +: 8] = data[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else if (access && read_en) begin
          rd1_d   = port_val(read_addr1, mem_q[read_addr1], wr_ok, write_addr, merged);
          rd2_d   = port_val(read_addr2, mem_q[read_addr2], wr_ok, write_addr, merged);
          valid_d = 1'b1;
        end
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == CLEAR) begin
      mem_q[idx_q] <= '0;
    end else if (wr_ok) begin
      mem_q[write_addr] <= merged;
    end
  end

  assign read_out1  = rd1_q;
  assign read_out2  = rd2_q;
  assign read_valid = valid_q;
  assign busy       = (state_q == CLEAR);

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed self-checking bench for reg_file_param
// Two instances share stimulus: one with bypass, one without.
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, read_en, write_en, clear_req;
  logic [4:0]  read_addr1, read_addr2, write_addr;
  logic [31:0] data;
  logic [3:0]  wr_mask;
  logic [31:0] ro1_b, ro2_b, ro1_n, ro2_n;
  logic        rv_b, rv_n, busy_b, busy_n;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_file_param #(.BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .read_en(read_en), .write_en(write_en),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .write_addr(write_addr),
    .data(data), .wr_mask(wr_mask), .clear_req(clear_req),
    .read_out1(ro1_b), .read_out2(ro2_b), .read_valid(rv_b), .busy(busy_b));

  reg_file_param #(.BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .enable(enable), .read_en(read_en), .write_en(write_en),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .write_addr(write_addr),
    .data(data), .wr_mask(wr_mask), .clear_req(clear_req),
    .read_out1(ro1_n), .read_out2(ro2_n), .read_valid(rv_n), .busy(busy_n));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    write_en = 1'b1; write_addr = a; data = d; wr_mask = m;
    cyc();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    read_en = 1'b1; read_addr1 = a1; read_addr2 = a2;
    cyc();
    read_en = 1'b0;
  endtask

  task automatic chk_both(input string tag, input logic [31:0] e1, input logic [31:0] e2);
    chk({tag, "_b1"}, ro1_b, e1);
    chk({tag, "_b2"}, ro2_b, e2);
    chk({tag, "_n1"}, ro1_n, e1);
    chk({tag, "_n2"}, ro2_n, e2);
  endtask

  initial begin
    int nb, nn;
    reset = 1'b0; enable = 1'b0; read_en = 1'b0; write_en = 1'b0; clear_req = 1'b0;
    read_addr1 = '0; read_addr2 = '0; write_addr = '0; data = '0; wr_mask = '0;

    repeat (3) cyc();
    chk("rst_ro1", ro1_b, 32'h0);
    chk("rst_valid", {31'b0, rv_b}, 32'h0);
    chk("rst_busy", {31'b0, busy_b}, 32'h0);
    reset = 1'b1;
    enable = 1'b1;

    rd(5'd1, 5'd31);
    chk_both("rd_after_rst", 32'h0, 32'h0);
    chk("rd_valid", {31'b0, rv_b}, 32'h1);
    chk("rd_busy", {31'b0, busy_b}, 32'h0);
    cyc();
    chk("valid_drop", {31'b0, rv_b}, 32'h0);

    wr(5'd5, 32'hDEADBEEF, 4'b1111);
    wr(5'd5, 32'h00001122, 4'b0011);
    rd(5'd5, 5'd5);
    chk_both("masked", 32'hDEAD1122, 32'hDEAD1122);

    wr(5'd7, 32'hAAAAAAAA, 4'b1111);
    write_en = 1'b1; write_addr = 5'd7; data = 32'h12345678; wr_mask = 4'b1100;
    read_en = 1'b1; read_addr1 = 5'd7; read_addr2 = 5'd5;
    cyc();
    write_en = 1'b0; read_en = 1'b0;
    chk("byp_on", ro1_b, 32'h1234AAAA);
    chk("byp_off", ro1_n, 32'hAAAAAAAA);
    chk("byp_other", ro2_b, 32'hDEAD1122);
    rd(5'd7, 5'd7);
    chk_both("byp_after", 32'h1234AAAA, 32'h1234AAAA);

    wr(5'd9, 32'h0BADF00D, 4'b0000);
    rd(5'd9, 5'd9);
    chk_both("mask0", 32'h0, 32'h0);

    write_en = 1'b1; write_addr = 5'd0; data = 32'hFFFFFFFF; wr_mask = 4'b1111;
    read_en = 1'b1; read_addr1 = 5'd0; read_addr2 = 5'd5;
    cyc();
    write_en = 1'b0; read_en = 1'b0;
    chk_both("r0_same", 32'h0, 32'hDEAD1122);
    rd(5'd0, 5'd0);
    chk_both("r0_later", 32'h0, 32'h0);

    enable = 1'b0;
    wr(5'd12, 32'h55555555, 4'b1111);
    rd(5'd12, 5'd12);
    chk("en0_valid", {31'b0, rv_b}, 32'h0);
    enable = 1'b1;

    for (int i = 0; i < 32; i++) wr(5'(i), 32'h01000000 + 32'(i) * 32'h11, 4'b1111);
    rd(5'd3, 5'd31);
    chk_both("fill", 32'h01000033, 32'h0100020F);

    clear_req = 1'b1;
    read_en = 1'b1; read_addr1 = 5'd3; read_addr2 = 5'd31;
    write_en = 1'b1; write_addr = 5'd2; data = 32'hFFFFFFFF; wr_mask = 4'b1111;
    cyc();
    clear_req = 1'b0;
    nb = 0; nn = 0;
    for (int k = 0; k < 40 && (busy_b || busy_n); k++) begin
      if (busy_b) nb++;
      if (busy_n) nn++;
      chk("clr_valid", {31'b0, rv_b | rv_n}, 32'h0);
      if (k == 5) clear_req = 1'b1;
      if (k == 6) clear_req = 1'b0;
      cyc();
    end
    read_en = 1'b0; write_en = 1'b0;
    chk("clr_len_b", 32'(nb), 32'd32);
    chk("clr_len_n", 32'(nn), 32'd32);
    chk("clr_hold", ro1_b, 32'h01000033);
    for (int i = 0; i < 32; i += 2) begin
      rd(5'(i), 5'(i + 1));
      chk_both("clr_zero", 32'h0, 32'h0);
    end

    wr(5'd20, 32'hCAFEF00D, 4'b1111);
    wr(5'd30, 32'h87654321, 4'b1111);
    rd(5'd20, 5'd30);
    chk_both("pre_abort", 32'hCAFEF00D, 32'h87654321);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    repeat (10) cyc();
    chk("mid_busy", {31'b0, busy_b}, 32'h1);
    chk("mid_hold", ro1_b, 32'hCAFEF00D);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'b0, busy_b | busy_n}, 32'h0);
    chk("abort_valid", {31'b0, rv_b | rv_n}, 32'h0);
    chk_both("abort_ro", 32'h0, 32'h0);
    cyc();
    reset = 1'b1;
    rd(5'd20, 5'd30);
    chk_both("abort_zero", 32'h0, 32'h0);
    wr(5'd20, 32'h13572468, 4'b1111);
    rd(5'd20, 5'd0);
    chk_both("resume", 32'h13572468, 32'h0);
    chk("resume_busy", {31'b0, busy_b}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised two-read/one-write register file for the datapath, succeeding the fixed 32x32 register file. Adds configurable width and depth, an optional hardwired-zero register 0, byte-masked writes, optional write-to-read bypass, and a sequenced clear engine that zeroes the array one entry per cycle while signalling busy. Reads are registered, so data appears one cycle after the request, with a valid strobe.

## Interface
- DATA_W, 32: register width in bits; must be a multiple of 8.
- DEPTH, 32: number of registers; 2..256.
- ADDR_W, 5: address width; must satisfy 2**ADDR_W >= DEPTH.
- R0_ZERO, 1: 1 = register 0 always reads 0 and ignores writes.
- BYPASS, 1: 1 = same-cycle write data is forwarded to a matching read.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears array, outputs and FSM.
- enable  input  1  global access enable; 0 = no read or write this cycle.
- read_en  input  1  read request; both ports are sampled together.
- write_en  input  1  write request.
- read_addr1  input  ADDR_W  port 1 read address.
- read_addr2  input  ADDR_W  port 2 read address.
- write_addr  input  ADDR_W  write address.
- data  input  DATA_W  write data.
- wr_mask  input  DATA_W/8  byte write enables; bit i covers data[8i+7:8i].
- clear_req  input  1  starts a sequenced clear of the whole array.
- read_out1  output  DATA_W  registered port 1 read data.
- read_out2  output  DATA_W  registered port 2 read data.
- read_valid  output  1  1 for one cycle when read_out1/2 carry new data.
- busy  output  1  1 while the clear engine runs.

## Operation
- Access cycle: a cycle with enable=1, FSM in IDLE, and clear_req=0.
- Write:
  - Happens in an access cycle with write_en=1.
  - Each byte with wr_mask=1 is replaced; the other bytes are kept.
  - wr_mask=0 leaves the register unchanged.
- Read:
  - Happens in an access cycle with read_en=1.
  - read_out1/2 are loaded with the contents of read_addr1/2 and read_valid=1 the next cycle.
  - In any other cycle, read_out1/2 hold their value and read_valid=0.
- Read/write collision (same cycle, read address equals write address):
  - BYPASS=1: the read returns the post-write merged value (old bytes plus new masked bytes).
  - BYPASS=0: the read returns the pre-write value.
- R0_ZERO=1:
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, including under bypass.
- Address >= DEPTH: writes are discarded; reads return 0.
- Clear engine FSM, states IDLE and CLEAR, with an ADDR_W-bit index:
  - IDLE -> CLEAR when clear_req=1 (independent of enable). Index is set to 0. Any read or write requested that cycle is dropped.
  - In CLEAR, each cycle zeroes register[index] and increments index. All read and write requests are ignored and read_valid=0.
  - CLEAR -> IDLE in the cycle the entry at index DEPTH-1 is zeroed.
  - clear_req while in CLEAR is ignored; the sweep is not restarted.
- busy=1 exactly when the FSM is in CLEAR.
- Asynchronous reset, while reset=0:
  - All registers, read_out1, read_out2, read_valid and busy are 0.
  - FSM is in IDLE, index is 0.
  - A reset in the middle of a clear aborts it.
  - The first access is possible on the first rising edge after reset returns to 1.

## Timing
- Read latency: 1 cycle. Request at edge N; data and read_valid are visible after edge N+1's update, i.e. in cycle N+1.
- Write latency: contents are updated at edge N.
  - A read of the same address issued at edge N+1 returns the new value in both BYPASS modes.
- Throughput: one write and two reads every cycle, no stalls outside CLEAR.
- Clear duration: busy rises after the edge that samples clear_req and stays high for exactly DEPTH cycles.
  - The first access is accepted on the edge where busy is seen low.
- No combinational path from any input to any output.

## Test plan
- Reset and readback:
  - Hold reset=0 for 3 cycles, release.
  - Read addresses 1 and 31 -> read_out1=read_out2=0, read_valid=1 one cycle later, busy=0.
- Masked write:
  - Write 0xDEADBEEF to reg 5 with wr_mask=4'b1111, then 0x00001122 with wr_mask=4'b0011.
  - Read reg 5 -> 0xDEAD1122.
- Bypass:
  - Reg 7=0xAAAAAAAA. In the same cycle write 0x12345678 with mask 4'b1100 and read reg 7.
  - BYPASS=1 -> 0x1234AAAA. BYPASS=0 -> 0xAAAAAAAA, then a following read -> 0x1234AAAA.
- Register 0 (R0_ZERO=1):
  - Write 0xFFFFFFFF to reg 0, with a simultaneous read of reg 0 -> 0.
  - Later read of reg 0 -> 0.
- Clear sweep (DEPTH=32):
  - Fill regs 0..31 with nonzero values, pulse clear_req, request reads and writes during busy.
  - busy=1 for exactly 32 cycles, read_valid=0 throughout, the requests have no effect.
  - Afterwards every register reads 0.
- Reset mid-clear:
  - Assert reset=0 at sweep index 10.
  - busy, read_out1, read_out2 and read_valid go to 0 immediately; every register reads 0; normal access resumes.
